// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MAR load, SRAM access wait and MDR load.
// Optional sticky stray-request flag enabled by MEM_ACCESS_CTRL_ERR_EN.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Req,
  input  logic RW,
  output logic LDMAR,
  output logic LDMDR,
  output logic MIOEN,
  output logic CE_N,
  output logic OE_N,
  output logic WE_N,
  output logic Busy,
  output logic Ready,
  output logic Err
);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("WAIT_CYCLES must be in 1..15");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    RD_WAIT,
    RD_LATCH,
    WR_DATA,
    WR_WAIT,
    DONE
  } state_t;

  localparam logic [3:0] LOAD = 4'(WAIT_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic       rw_q;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;

  logic ldmar_nx;
  logic ldmdr_nx;
  logic mioen_nx;
  logic ce_n_nx;
  logic oe_n_nx;
  logic we_n_nx;
  logic busy_nx;
  logic ready_nx;

  // Next state and wait counter; counter holds at zero rather than wrapping
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (Req) state_nx = ADDR;
      end
      ADDR: begin
        cnt_nx   = LOAD;
        state_nx = rw_q ? WR_DATA : RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt == 4'd0) state_nx = RD_LATCH;
        else cnt_nx = cnt - 4'd1;
      end
      RD_LATCH: state_nx = DONE;
      WR_DATA: begin
        cnt_nx   = LOAD;
        state_nx = WR_WAIT;
      end
      WR_WAIT: begin
        if (cnt == 4'd0) state_nx = DONE;
        else cnt_nx = cnt - 4'd1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes for the upcoming state, registered so outputs track state only
  always_comb begin
    ldmar_nx = (state_nx == ADDR);
    ldmdr_nx = (state_nx == RD_LATCH) || (state_nx == WR_DATA);
    mioen_nx = (state_nx == RD_LATCH);
    oe_n_nx  = !((state_nx == RD_WAIT) || (state_nx == RD_LATCH));
    we_n_nx  = !(state_nx == WR_WAIT);
    ce_n_nx  = oe_n_nx && we_n_nx;
    busy_nx  = (state_nx != IDLE);
    ready_nx = (state_nx == DONE);
  end

  // State register, latched access type and registered strobes
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rw_q  <= 1'b0;
      LDMAR <= 1'b0;
      LDMDR <= 1'b0;
      MIOEN <= 1'b0;
      CE_N  <= 1'b1;
      OE_N  <= 1'b1;
      WE_N  <= 1'b1;
      Busy  <= 1'b0;
      Ready <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && Req) rw_q <= RW;
      LDMAR <= ldmar_nx;
      LDMDR <= ldmdr_nx;
      MIOEN <= mioen_nx;
      CE_N  <= ce_n_nx;
      OE_N  <= oe_n_nx;
      WE_N  <= we_n_nx;
      Busy  <= busy_nx;
      Ready <= ready_nx;
    end
  end

`ifdef MEM_ACCESS_CTRL_ERR_EN
  // Sticky flag for a request arriving while an access is in flight
  always_ff @(posedge Clk) begin
    if (!Reset) Err <= 1'b0;
    else if (Req && state != IDLE) Err <= 1'b1;
  end
`else
  assign Err = 1'b0;
`endif

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the CPU memory port. It owns the MAR/MDR/MIO-mux datapath and the SRAM control strobes, turning a single-cycle CPU read or write request into the ordered load-MAR, access-wait and load-MDR steps. It sits between the CPU control FSM and the MAR, MDR, MIO mux and SRAM chip-enable pins. Access length is set by a parameterised wait-state count.

## Interface
Parameters:
- WAIT_CYCLES, 2: SRAM access wait states; legal range 1..15.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Req  in  1  one-cycle access request pulse; sampled only in IDLE.
- RW  in  1  access type, sampled with Req: 0 = read, 1 = write.
- LDMAR  out  1  MAR load enable.
- LDMDR  out  1  MDR load enable.
- MIOEN  out  1  MIO mux select: 1 = memory data into MDR, 0 = datapath into MDR.
- CE_N  out  1  SRAM chip enable, active low.
- OE_N  out  1  SRAM output enable, active low.
- WE_N  out  1  SRAM write enable, active low.
- Busy  out  1  high in every state except IDLE.
- Ready  out  1  one-cycle completion pulse.
- Err  out  1  sticky protocol-error flag (see Configuration).

## Operation
- States: IDLE, ADDR, RD_WAIT, RD_LATCH, WR_DATA, WR_WAIT, DONE.
- All outputs are decoded from the state register only. No input reaches an output combinationally.
- IDLE: all strobes are inactive (CE_N/OE_N/WE_N = 1; LDMAR/LDMDR/MIOEN = 0). If Req = 1, latch RW and go to ADDR.
- ADDR: LDMAR = 1. Go to RD_WAIT if the latched RW = 0, or to WR_DATA if it = 1. Load the wait counter with WAIT_CYCLES-1.
- RD_WAIT: CE_N = 0 and OE_N = 0. Decrement the counter; when it is 0, go to RD_LATCH.
- RD_LATCH: CE_N = 0, OE_N = 0, MIOEN = 1, LDMDR = 1. Go to DONE.
- WR_DATA: LDMDR = 1 and MIOEN = 0, so MDR captures the datapath. Reload the counter and go to WR_WAIT.
- WR_WAIT: CE_N = 0 and WE_N = 0. Decrement the counter; when it is 0, go to DONE. WE_N is never low in the same cycle as LDMDR.
- DONE: Ready = 1, all strobes inactive. Go to IDLE unconditionally.
- OE_N and WE_N are never both low. LDMAR and LDMDR are never both high.
- Req outside IDLE is ignored. A new request requires at least one IDLE cycle after DONE.
- The wait counter is 4 bits wide and does not wrap. WAIT_CYCLES outside 1..15 is a static elaboration error.

## Timing
- Reset = 0 at an edge forces IDLE, clears the counter and clears Err, from any state including mid-access.
- While in reset: CE_N = OE_N = WE_N = 1; LDMAR = LDMDR = MIOEN = Busy = Ready = Err = 0.
- Reset aborts an in-flight write on the same edge. WE_N returns high in the cycle after reset is sampled.
- Read, Req high in cycle n:
  - ADDR in n+1.
  - RD_WAIT for n+2 .. n+1+W.
  - RD_LATCH in n+2+W.
  - Ready in n+3+W.
- Write has the same latency: Ready in n+3+W, with WE_N low for exactly W cycles.
- Busy is high from n+1 through n+3+W inclusive.
- Minimum request spacing is W+4 cycles.

## Configuration
- MEM_ACCESS_CTRL_ERR_EN defined:
  - Err is set on any edge where Req = 1 and the state is not IDLE.
  - Err stays high until reset. Sequencing is unaffected.
- MEM_ACCESS_CTRL_ERR_EN undefined:
  - Err is tied to 0 and no error logic is built.
  - Stray Req is silently ignored.

## Test plan
- Reset is asserted for 3 cycles, then released with Req = 0. Required: all outputs hold their reset values, Busy = 0, and the state stays IDLE for 10 cycles.
- W = 2, read, Req pulse in cycle 5. Required:
  - LDMAR = 1 in cycle 6.
  - OE_N = 0 in cycles 7–9.
  - LDMDR = MIOEN = 1 in cycle 9 only.
  - Ready = 1 in cycle 10 only.
  - WE_N stays 1 throughout.
- W = 2, write, Req pulse in cycle 5. Required:
  - LDMAR in cycle 6.
  - LDMDR = 1 with MIOEN = 0 in cycle 7.
  - WE_N = 0 in cycles 8–9.
  - Ready in cycle 10.
  - OE_N stays 1 throughout.
- Back-to-back: a write Req in cycle 5, then a read Req in cycle 11 (the IDLE cycle after DONE). Required: the read completes with Ready in cycle 16, and LDMAR and LDMDR never overlap.
- Reset = 0 in cycle 8 during a W = 2 write. Required: WE_N = 1 from cycle 9 and state IDLE; a subsequent read Req in cycle 12 completes with Ready in cycle 17.
- With the macro defined, Req is pulsed in cycle 7 during a read that started in cycle 5. Required: Err = 1 from cycle 8 and stays high, the read still gives Ready in cycle 10, and Err clears only after reset. With the macro undefined, the same stimulus gives Err = 0 throughout.
